// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divider.
package div_pkg;

  localparam int DIV_ITER    = 32;
  localparam int DIV_LATENCY = 34;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_sub_stage.sv
// 33-bit trial subtract for one restoring-division step; purely combinational.
// No state, no handshake: the result is valid in the same cycle.
module div_sub_stage (
  input  logic [32:0] a,
  input  logic [32:0] b,
  output logic [32:0] diff,
  output logic        nonneg
);

  assign diff   = a - b;
  assign nonneg = ~diff[32];

endmodule

// File: rtl/div_unit_32.sv
// RV32M DIV/DIVU/REM/REMU, radix-2 restoring, fixed 34-cycle start-to-valid latency.
// No backpressure: caller stalls on o_busy; i_start while busy is dropped.
module div_unit_32
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  div_state_e      state, state_nxt;
  div_op_e         op_in;
  logic            sel_rem, neg_q, neg_r, dz;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quo, dvs;
  logic [5:0]      cnt;

  logic            in_signed, accept;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   rem_sh, trial;
  logic            trial_ok;
  logic [XLEN-1:0] q_fix, r_fix, res_fix;

  assign op_in     = div_op_e'(i_op);
  assign in_signed = (op_in == DIV) || (op_in == REM);
  assign accept    = (state == IDLE) && i_start && !i_flush;
  assign abs1      = (in_signed && i_rs1[XLEN-1]) ? -i_rs1 : i_rs1;
  assign abs2      = (in_signed && i_rs2[XLEN-1]) ? -i_rs2 : i_rs2;

  // rem never exceeds the divisor, so its top bit drops out of the shift.
  assign rem_sh = (rem << 1) | {{XLEN{1'b0}}, quo[XLEN-1]};

  div_sub_stage u_sub (
    .a      (rem_sh),
    .b      ({1'b0, dvs}),
    .diff   (trial),
    .nonneg (trial_ok)
  );

  // Divide-by-zero: the core already leaves |rs1| in rem, only the quotient needs forcing.
  assign q_fix   = dz ? {XLEN{1'b1}} : (neg_q ? -quo : quo);
  assign r_fix   = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  assign res_fix = sel_rem ? r_fix : q_fix;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC: begin
        if (i_flush)                        state_nxt = IDLE;
        else if (cnt == 6'(DIV_ITER - 1))   state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sel_rem  <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else begin
      o_busy  <= (state_nxt != IDLE);
      o_valid <= (state == FIX) && !i_flush;
      if (accept) begin
        sel_rem <= (op_in == REM) || (op_in == REMU);
        neg_q   <= in_signed && (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]);
        neg_r   <= in_signed && i_rs1[XLEN-1];
        dz      <= (i_rs2 == '0);
        rem     <= '0;
        quo     <= abs1;
        dvs     <= abs2;
        cnt     <= '0;
      end
      if (state == CALC && !i_flush) begin
        rem <= trial_ok ? trial : rem_sh;
        quo <= {quo[XLEN-2:0], trial_ok};
        cnt <= cnt + 6'd1;
      end
      if (state == FIX && !i_flush) o_result <= res_fix;
    end
  end

endmodule

// File: tb/tb_div_unit_32.sv
// Randomized and directed bench for div_unit_32 against an arithmetic reference model.
module tb_div_unit_32;
  import div_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_flush;
  logic [1:0]  i_op;
  logic [31:0] i_rs1, i_rs2;
  logic        o_busy, o_valid;
  logic [31:0] o_result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  div_unit_32 #(.XLEN(32)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_flush  (i_flush),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    sa = a;
    sb = b;
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  // Called right after a falling edge: that cycle is cycle 0 of the request.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int intr_cyc, output logic [31:0] res, output int lat);
    lat = -1;
    res = 32'd0;
    i_op = op; i_rs1 = a; i_rs2 = b; i_start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge i_clk);
      if (c == 1) begin
        i_start = 1'b0;
        chk("busy_c1", {31'd0, o_busy}, 32'd1);
      end
      if (c == intr_cyc) begin
        i_start = 1'b1; i_rs1 = ~a; i_rs2 = 32'd1; i_op = op ^ 2'b10;
      end else if (c == intr_cyc + 1) begin
        i_start = 1'b0;
      end
      if (c == 33) chk("busy_c33", {31'd0, o_busy}, 32'd1);
      if (o_valid) begin
        lat = c;
        res = o_result;
        chk("busy_at_valid", {31'd0, o_busy}, 32'd0);
        break;
      end
    end
  endtask

  logic [1:0]  d_op  [9] = '{DIVU, REMU, DIV, REM, REM, DIV, REMU, DIV, REM};
  logic [31:0] d_a   [9] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5,
                             32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b   [9] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp [9] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF,
                             32'h1234_5678, 32'h8000_0000, 32'd0};

  initial begin
    logic [31:0] res, prev, a, b;
    logic [1:0]  op;
    int          lat, nv;

    i_rst = 1'b1; i_start = 1'b0; i_flush = 1'b0; i_op = 2'b00; i_rs1 = '0; i_rs2 = '0;
    repeat (2) @(negedge i_clk);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    for (int i = 0; i < 9; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], -1, res, lat);
      chk($sformatf("dir%0d_res", i), res, d_exp[i]);
      chk($sformatf("dir%0d_lat", i), 32'(lat), 32'(DIV_LATENCY));
    end

    // Start while busy must be ignored.
    run_op(DIVU, 32'd9, 32'd3, 10, res, lat);
    chk("intr_res", res, 32'd3);
    chk("intr_lat", 32'(lat), 32'(DIV_LATENCY));
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      chk("intr_no_extra", {31'd0, o_valid}, 32'd0);
    end

    // Back-to-back: second start lands in the first op's valid cycle.
    run_op(DIVU, 32'd9, 32'd3, -1, res, lat);
    chk("b2b_first", res, 32'd3);
    run_op(REMU, 32'd10, 32'd4, -1, res, lat);
    chk("b2b_second", res, 32'd2);
    chk("b2b_lat", 32'(lat), 32'(DIV_LATENCY));
    prev = 32'd2;

    // Flush mid-calc.
    i_op = DIV; i_rs1 = 32'd1000; i_rs2 = 32'd3; i_start = 1'b1;
    nv = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge i_clk);
      if (c == 1) i_start = 1'b0;
      if (o_valid) nv++;
      if (c == 20) i_flush = 1'b1;
      if (c == 21) begin
        i_flush = 1'b0;
        chk("flush_idle", {31'd0, o_busy}, 32'd0);
      end
    end
    chk("flush_novalid", 32'(nv), 32'd0);
    chk("flush_hold", o_result, prev);

    // Flush together with start in IDLE: nothing starts.
    i_op = DIVU; i_rs1 = 32'd50; i_rs2 = 32'd5; i_start = 1'b1; i_flush = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_flush = 1'b0;
    chk("flush_start_busy", {31'd0, o_busy}, 32'd0);
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_valid) nv++;
    end
    chk("flush_start_novalid", 32'(nv), 32'd0);

    // Reset mid-operation.
    i_op = REMU; i_rs1 = 32'd77; i_rs2 = 32'd5; i_start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge i_clk);
      if (c == 1) i_start = 1'b0;
    end
    i_rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    chk("arst_valid", {31'd0, o_valid}, 32'd0);
    chk("arst_result", o_result, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_valid) nv++;
    end
    chk("arst_novalid", 32'(nv), 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin
          a = 32'($urandom_range(0, 300));
          b = 32'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      run_op(op, a, b, -1, res, lat);
      chk($sformatf("rand%0d_res op=%0d a=%h b=%h", i, op, a, b), res, ref_div(op, a, b));
      chk($sformatf("rand%0d_lat", i), 32'(lat), 32'(DIV_LATENCY));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
